// File: rtl/ascon_params.sv
// Shared parameters, FSM encoding and round helpers for the masked
// Ascon permutation engine.
package ascon_params;
   localparam int D          = 2;
   localparam int NS         = D + 1;
   localparam int NR         = D * (D + 1) / 2;
   localparam int MAX_ROUNDS = 12;
   localparam int SW         = 320;

   typedef enum logic [1:0] {IDLE, SBOX, LIN, DONE} fsm_t;

   function automatic logic [7:0] round_const(input logic [3:0] idx);
      return {4'hF - idx, idx};
   endfunction

   function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [63:0] ascon_linear(input logic [63:0] x, input int w);
      case (w)
         0:       return x ^ ror64(x, 19) ^ ror64(x, 28);
         1:       return x ^ ror64(x, 61) ^ ror64(x, 39);
         2:       return x ^ ror64(x, 1)  ^ ror64(x, 6);
         3:       return x ^ ror64(x, 10) ^ ror64(x, 17);
         default: return x ^ ror64(x, 7)  ^ ror64(x, 41);
      endcase
   endfunction
endpackage

// File: rtl/ascon_masked_round_ctrl_sbox_layer.sv
// 64-column masked S-box layer: bit-slices the shared 320-bit state into
// columns and reassembles the registered column outputs.
module ascon_sbox_layer
   import ascon_params::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [SW*NS-1:0]   state_in,
   input  logic [64*NR-1:0]   rand_in,
   output logic [SW*NS-1:0]   state_out
);
   for (genvar b = 0; b < 64; b++) begin : g_col
      logic [4:0][NS-1:0] cx;
      logic [4:0][NS-1:0] cy;
      for (genvar w = 0; w < 5; w++) begin : g_word
         for (genvar s = 0; s < NS; s++) begin : g_share
            assign cx[w][s] = state_in[SW*s + 64*w + b];
            assign state_out[SW*s + 64*w + b] = cy[w][s];
         end
      end
      ascon_sbox_d2 u_sbox (
         .clk              (clk),
         .rst              (rst),
         .en               (en),
         .sel_masked_round (1'b1),
         .x_in             (cx),
         .fresh_r          (rand_in[NR*b +: NR]),
         .x_out            (cy)
      );
   end
endmodule

// File: rtl/ascon_sbox_d2.sv
// One masked Ascon chi column (5 bits x NS shares), DOM-style share
// products re-masked with NR fresh bits, output registered.
module ascon_sbox_d2
   import ascon_params::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 sel_masked_round,
   input  logic [4:0][NS-1:0]   x_in,
   input  logic [NR-1:0]        fresh_r,
   output logic [4:0][NS-1:0]   x_out
);
   function automatic int pair_idx(input int lo, input int hi);
      return lo * NS - (lo * (lo + 1)) / 2 + (hi - lo - 1);
   endfunction

   // masked (~a & b); the inversion touches share 0 only
   function automatic logic [NS-1:0] masked_andn(input logic [NS-1:0] a,
                                                 input logic [NS-1:0] b,
                                                 input logic [NR-1:0] r,
                                                 input logic          use_r);
      logic [NS-1:0] na;
      logic [NS-1:0] t;
      na    = a;
      na[0] = ~a[0];
      t     = '0;
      for (int s = 0; s < NS; s++) begin
         for (int j = 0; j < NS; j++) begin
            t[s] = t[s] ^ (na[s] & b[j]);
            if (use_r && s < j)      t[s] = t[s] ^ r[pair_idx(s, j)];
            else if (use_r && s > j) t[s] = t[s] ^ r[pair_idx(j, s)];
         end
      end
      return t;
   endfunction

   logic [4:0][NS-1:0] chi;

   always_comb begin
      chi = '0;
      for (int i = 0; i < 5; i++)
         chi[i] = x_in[i] ^ masked_andn(x_in[(i + 1) % 5], x_in[(i + 2) % 5],
                                        fresh_r, sel_masked_round);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     x_out <= '0;
      else if (en) x_out <= chi;
   end
endmodule

// File: rtl/ascon_masked_round_ctrl.sv
// Masked Ascon permutation round controller: FSM, constant/affine layers,
// linear diffusion and the shared state register around the S-box layer.
//
// state | meaning
// IDLE  | waiting for start, in_ready high
// SBOX  | S-box inputs presented, waits for fresh randomness
// LIN   | post-affine + diffusion written back, round index advances
// DONE  | one-cycle done pulse, state_out final
module ascon_masked_round_ctrl
   import ascon_params::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [3:0]         rounds,
   input  logic [SW*NS-1:0]   state_in,
   output logic               in_ready,
   input  logic               rand_valid,
   input  logic [64*NR-1:0]   rand_in,
   output logic               rand_ready,
   output logic [SW*NS-1:0]   state_out,
   output logic               done,
   output logic               busy
);
   fsm_t               fsm;
   logic [3:0]         rc_idx;
   logic [3:0]         rounds_eff;
   logic [SW*NS-1:0]   st_q;
   logic [SW*NS-1:0]   rc_added;
   logic [SW*NS-1:0]   sbox_in;
   logic [SW*NS-1:0]   sbox_out;
   logic [SW*NS-1:0]   lin_out;

   function automatic logic [SW-1:0] pre_share(input logic [SW-1:0] sh);
      logic [63:0] x0, x1, x2, x3, x4;
      {x4, x3, x2, x1, x0} = sh;
      x0 = x0 ^ x4;
      x4 = x4 ^ x3;
      x2 = x2 ^ x1;
      return {x4, x3, x2, x1, x0};
   endfunction

   function automatic logic [SW-1:0] post_share(input logic [SW-1:0] sh,
                                               input logic        first);
      logic [63:0] x0, x1, x2, x3, x4;
      {x4, x3, x2, x1, x0} = sh;
      x1 = x1 ^ x0;
      x0 = x0 ^ x4;
      x3 = x3 ^ x2;
      if (first) x2 = ~x2;
      return {ascon_linear(x4, 4), ascon_linear(x3, 3), ascon_linear(x2, 2),
              ascon_linear(x1, 1), ascon_linear(x0, 0)};
   endfunction

   assign rounds_eff = (rounds == 4'd0 || rounds > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : rounds;
   assign state_out  = st_q;
   assign rand_ready = (fsm == SBOX) && rand_valid;

   // round constant lands on the low byte of x2, share 0 only
   always_comb begin
      rc_added            = st_q;
      rc_added[128 +: 8]  = st_q[128 +: 8] ^ round_const(rc_idx);
   end

   always_comb begin
      sbox_in = '0;
      for (int s = 0; s < NS; s++)
         sbox_in[SW*s +: SW] = pre_share(rc_added[SW*s +: SW]);
   end

   ascon_sbox_layer u_layer (
      .clk       (clk),
      .rst       (rst),
      .en        (rand_ready),
      .state_in  (sbox_in),
      .rand_in   (rand_in),
      .state_out (sbox_out)
   );

   always_comb begin
      lin_out = '0;
      for (int s = 0; s < NS; s++)
         lin_out[SW*s +: SW] = post_share(sbox_out[SW*s +: SW], s == 0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm      <= IDLE;
         st_q     <= '0;
         rc_idx   <= '0;
         done     <= 1'b0;
         busy     <= 1'b0;
         in_ready <= 1'b1;
      end else begin
         done <= 1'b0;
         case (fsm)
            IDLE: begin
               if (start) begin
                  st_q     <= state_in;
                  rc_idx   <= 4'(MAX_ROUNDS) - rounds_eff;
                  fsm      <= SBOX;
                  busy     <= 1'b1;
                  in_ready <= 1'b0;
               end
            end
            SBOX: begin
               if (rand_valid) fsm <= LIN;
            end
            LIN: begin
               st_q   <= lin_out;
               rc_idx <= rc_idx + 4'd1;
               if (rc_idx == 4'(MAX_ROUNDS - 1)) begin
                  fsm  <= DONE;
                  done <= 1'b1;
               end else begin
                  fsm <= SBOX;
               end
            end
            DONE: begin
               fsm      <= IDLE;
               busy     <= 1'b0;
               in_ready <= 1'b1;
            end
            default: fsm <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/ascon_masked_round_ctrl.md
Name: ascon_masked_round_ctrl

Overview:
- Masked ASCON permutation engine: holds the full 320-bit state as NS=d+1 Boolean shares.
- Runs a configurable number of rounds. Each round applies, in order: constant addition, affine pre-layer, the 64-column masked S-box layer (64 instances of ascon_sbox_d2), affine post-layer and linear diffusion.
- Sits directly upstream/downstream of the S-box layer: drives its x_in/fresh_r, consumes its registered x_out.
- Feeds the masked AEAD mode controller.

Parameters:
- d, from ascon_params: masking order; NS = d+1 shares.
- NR, = d*(d+1)/2: fresh bits per S-box per round.
- MAX_ROUNDS, 12: full permutation length; constant schedule base.

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- start  in  1  request permutation; accepted only when in_ready=1
- rounds  in  4  round count; legal 1..12; 0 or >12 treated as 12
- state_in  in  320*NS  share s at [320*s +: 320]; word w at [64*w +: 64] within a share
- in_ready  out  1  high in IDLE
- rand_valid  in  1  fresh randomness present
- rand_in  in  64*NR  S-box b uses [NR*b +: NR]
- rand_ready  out  1  randomness consumed this cycle
- state_out  out  320*NS  registered masked state, same packing as state_in
- done  out  1  one-cycle pulse: state_out final
- busy  out  1  high outside IDLE

Behaviour:
- Reset (async, any state): FSM=IDLE; state register=0; round counter=0; done=0; busy=0; in_ready=1; rand_ready=0.
- Interface rule: one clock (clk); rst is asynchronous, active-high.
- FSM states: IDLE, SBOX, LIN, DONE.
- IDLE: on start=1, load state_in, set rc_idx = 12 - rounds_eff, go SBOX. start is ignored while busy.
- SBOX: build the S-box input combinationally from the state register:
  - Add c = ((0xF - rc_idx) << 4) | rc_idx to the low byte of x2, share 0 only.
  - Pre-affine on every share: x0 ^= x4; x4 ^= x3; x2 ^= x1.
  - Column b gets bit b of each word of each share: x[w][s] = share s, word w, bit b. sel_masked_round is tied 1.
  - rand_ready = rand_valid. If rand_valid=1, go LIN (S-box regs capture at this edge); else stay in SBOX, holding inputs stable.
- LIN: from the S-box x_out:
  - Post-affine per share: x1 ^= x0; x0 ^= x4; x3 ^= x2.
  - x2 = ~x2 on share 0 only; other shares of x2 unchanged.
  - Linear layer per share, rotate-right: x0: 19,28; x1: 61,39; x2: 1,6; x3: 10,17; x4: 7,41.
  - Write result to the state register; rc_idx += 1.
  - If rc_idx was 11, go DONE; else go SBOX.
- DONE: done=1 for this cycle only, then IDLE. state_out holds until the next accepted start.
- state_out is driven directly by the state register and reflects intermediate rounds while busy. Consumers sample on done.
- Latency, no stalls: start accepted at edge E0; done high in cycle 2r+1 after E0. Each rand_valid-low cycle in SBOX adds one cycle.
- Randomness: exactly one rand_in word consumed per round; never reused across rounds. Masked values are never recombined inside the block.
- rst during SBOX or LIN aborts the run with no done pulse; state is cleared.

Decomposition:
- ascon_params gains:
  - NS, NR, MAX_ROUNDS;
  - enum fsm_t {IDLE, SBOX, LIN, DONE};
  - function round_const(idx) returning 8 bits;
  - function ascon_linear(word, w) returning the diffused 64-bit word.
- One sub-module: ascon_sbox_layer. It wraps 64 ascon_sbox_d2 instances and handles bit-slice packing/unpacking of state and randomness. The parent holds the FSM, constant/affine logic and state register.

Test Plan:
- Zero state, all shares 0, rounds=1, rand constant:
  - done at cycle 3.
  - Recombined x1 = 0x0000000096000213 and x4 = 0.
  - Recombined x0 = 0x4B ^ ror(0x4B,19) ^ ror(0x4B,28).
- Random state, random shares, rounds=12 and 8 and 6, random rand_in each round: recombined state_out equals the unmasked golden Ascon p12/p8/p6. done at 25, 17 and 13 cycles.
- rand_valid held low 3 cycles in round 5 of a 12-round run:
  - rand_ready=0 during the stall.
  - Result unchanged vs no-stall; done at 28.
- start pulsed while busy: ignored, result unaffected. rounds=0 and rounds=15 behave as rounds=12.
- rst asserted asynchronously mid-LIN of round 3: outputs clear immediately, no done. A new start then completes correctly.
- Same plaintext state, two different share splits: identical recombined output. Per-share state_out differs from the unmasked value.
